lbp_window_gen: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the LBP processor in the SVM feature path. It accepts one detection-window patch of winCol x winRow pixels in raster order, at up to one pixel per clock. It buffers two previous rows and emits every fully-interior 3x3 neighbourhood as a 9-pixel packed word with a valid strobe. Output packing and ordering match the LBP processor's windowIn and enable_lbp inputs, so the two blocks connect directly.

---
 rtl/lbp_window_gen_pkg.sv | 25 ++
 rtl/lbp_line_buffer.sv | 34 +++
 rtl/lbp_window_gen.sv | 158 +++++++++++++++
 tb/tb_lbp_window_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_window_gen_pkg.sv
// Shared definitions for the LBP window generator.
// Holds the codebase log2 helper used to size counters and addresses, the
// window slot indices the LBP processor relies on, and the default patch size.
package lbp_window_gen_pkg;

    // Default detection-window patch geometry in pixels.
    localparam int DEFAULT_WIN_COL = 26;
    localparam int DEFAULT_WIN_ROW = 26;

    // Window slot layout: 8|7|6 top, 5|4|3 middle, 2|1|0 bottom.
    localparam int SLOT_NEWEST = 0;
    localparam int SLOT_CENTRE = 4;
    localparam int SLOT_COUNT  = 9;

    // Number of bits needed to index 'value' entries; never less than 1.
    function automatic int log2(input int value);
        int result;
        result = 32'sd1;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// Single-row line buffer for the window generator.
// Ports:
//   clock - write clock (posedge)
//   we    - write enable
//   addr  - shared read/write address (column index)
//   din   - write data
//   dout  - combinational read data; a read at the address being written in
//           the same cycle returns the old contents
// Contents are not reset; every entry is written before it is read in a patch.
module lbp_line_buffer
    import lbp_window_gen_pkg::*;
#(
    parameter int depth = DEFAULT_WIN_COL,
    parameter int width = 8
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [log2(depth)-1:0] addr,
    input  logic [width-1:0]       din,
    output logic [width-1:0]       dout
);

    logic [width-1:0] mem_r [0:depth-1];

    // Write port: the new value lands at the clock edge, after the read.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    assign dout = mem_r[addr];

endmodule

// File: rtl/lbp_window_gen.sv
// Streaming 3x3 window generator feeding the LBP processor.
// Accepts one winCol x winRow patch in raster order and emits every interior
// 3x3 neighbourhood, one clock after the pixel that completes it.
// Ports:
//   clock       - single clock, posedge
//   reset_lbp   - synchronous active-high reset
//   frame_start - pulse that (re)starts a patch at (0,0)
//   pixel_valid - pixel_in qualifier
//   pixel_in    - patch pixel, raster order
//   windowIn    - packed window, slot k at [k*inputWidth +: inputWidth]
//   enable_lbp  - windowIn valid strobe
//   frame_done  - pulse coincident with the final window of the patch
//   busy        - patch in progress
module lbp_window_gen
    import lbp_window_gen_pkg::*;
#(
    parameter int inputWidth = 8,
    parameter int winCol     = DEFAULT_WIN_COL,
    parameter int winRow     = DEFAULT_WIN_ROW
) (
    input  logic                      clock,
    input  logic                      reset_lbp,
    input  logic                      frame_start,
    input  logic                      pixel_valid,
    input  logic [inputWidth-1:0]     pixel_in,
    output logic [inputWidth*9-1:0]   windowIn,
    output logic                      enable_lbp,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int W  = inputWidth;
    localparam int CW = log2(winCol);
    localparam int RW = log2(winRow);

    localparam logic [CW-1:0] COL_LAST = CW'(winCol - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(winRow - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_ZERO = CW'(0);
    localparam logic [RW-1:0] ROW_ZERO = RW'(0);

    logic [CW-1:0]          col_r;
    logic [RW-1:0]          row_r;
    logic                   busy_r;
    logic                   enable_r;
    logic                   done_r;
    logic [W*SLOT_COUNT-1:0] window_r;

    logic                   accept_s;
    logic [CW-1:0]          col_s;
    logic [RW-1:0]          row_s;
    logic [CW-1:0]          col_next_s;
    logic [RW-1:0]          row_next_s;
    logic                   last_s;
    logic                   interior_s;
    logic [W-1:0]           row_a_s;   // pixel from row r-2
    logic [W-1:0]           row_b_s;   // pixel from row r-1

    // Position of the pixel on pixel_in this cycle; frame_start relabels it (0,0).
    always_comb begin
        accept_s   = pixel_valid & (busy_r | frame_start);
        col_s      = col_r;
        row_s      = row_r;
        col_next_s = col_r;
        row_next_s = row_r;
        if (frame_start) begin
            col_s = COL_ZERO;
            row_s = ROW_ZERO;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
        last_s     = (col_s == COL_LAST) && (row_s == ROW_LAST);
        interior_s = (col_s >= COL_TWO) && (row_s >= ROW_TWO);
        if (col_s == COL_LAST) begin
            col_next_s = COL_ZERO;
            if (row_s == ROW_LAST) begin
                row_next_s = ROW_ZERO;
            end else begin
                row_next_s = row_s + 1'b1;
            end
        end else begin
            col_next_s = col_s + 1'b1;
            row_next_s = row_s;
        end
    end

    // lb1 holds row r-1; its old entry cascades into lb2 as row r-2.
    lbp_line_buffer #(
        .depth (winCol),
        .width (W)
    ) u_lb1 (
        .clock (clock),
        .we    (accept_s),
        .addr  (col_s),
        .din   (pixel_in),
        .dout  (row_b_s)
    );

    lbp_line_buffer #(
        .depth (winCol),
        .width (W)
    ) u_lb2 (
        .clock (clock),
        .we    (accept_s),
        .addr  (col_s),
        .din   (row_b_s),
        .dout  (row_a_s)
    );

    // Counters, patch state, strobes and window shift register.
    always_ff @(posedge clock) begin
        if (reset_lbp) begin
            col_r    <= COL_ZERO;
            row_r    <= ROW_ZERO;
            busy_r   <= 1'b0;
            enable_r <= 1'b0;
            done_r   <= 1'b0;
            window_r <= '0;
        end else begin
            // Windows with c < 2 straddle a row boundary and are never flagged.
            enable_r <= accept_s & interior_s;
            done_r   <= accept_s & last_s;
            if (accept_s) begin
                col_r  <= col_next_s;
                row_r  <= row_next_s;
                busy_r <= ~last_s;
                // Oldest column: slots {8,5,2} take the previous {7,4,1}.
                window_r[8*W +: W] <= window_r[7*W +: W];
                window_r[5*W +: W] <= window_r[SLOT_CENTRE*W +: W];
                window_r[2*W +: W] <= window_r[1*W +: W];
                // Middle column: slots {7,4,1} take the previous {6,3,0}.
                window_r[7*W +: W]           <= window_r[6*W +: W];
                window_r[SLOT_CENTRE*W +: W] <= window_r[3*W +: W];
                window_r[1*W +: W]           <= window_r[SLOT_NEWEST*W +: W];
                // Newest column: slots {6,3,0} = rows r-2, r-1, r.
                window_r[6*W +: W]           <= row_a_s;
                window_r[3*W +: W]           <= row_b_s;
                window_r[SLOT_NEWEST*W +: W] <= pixel_in;
            end else if (frame_start) begin
                col_r  <= COL_ZERO;
                row_r  <= ROW_ZERO;
                busy_r <= 1'b1;
            end else begin
                col_r  <= col_r;
                row_r  <= row_r;
                busy_r <= busy_r;
            end
        end
    end

    assign windowIn   = window_r;
    assign enable_lbp = enable_r;
    assign frame_done = done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_lbp_window_gen.sv
// Self-checking bench for lbp_window_gen: directed ramp / stall / restart /
// reset patches, a table of hand-computed slot values and a full per-window
// comparison against a pixel-position model.
module tb_lbp_window_gen;
    import lbp_window_gen_pkg::*;

    localparam int W    = 8;
    localparam int COLS = 26;
    localparam int ROWS = 26;
    localparam int NWIN = (COLS - 2) * (ROWS - 2);

    logic          clock = 1'b0;
    logic          reset_lbp;
    logic          frame_start;
    logic          pixel_valid;
    logic [W-1:0]  pixel_in;
    logic [W*9-1:0] windowIn;
    logic          enable_lbp;
    logic          frame_done;
    logic          busy;

    always #5 clock = ~clock;

    lbp_window_gen #(
        .inputWidth (W),
        .winCol     (COLS),
        .winRow     (ROWS)
    ) dut (
        .clock       (clock),
        .reset_lbp   (reset_lbp),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .windowIn    (windowIn),
        .enable_lbp  (enable_lbp),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    typedef struct {
        logic [W*9-1:0] w;
        logic           fd;
    } strobe_t;

    typedef struct {
        int         idx;
        int         slot;
        logic [7:0] exp;
    } vec_t;

    strobe_t q[$];
    vec_t    tbl[9];
    int      done_cnt = 0;
    int      spur_cnt = 0;
    int      vec_cnt  = 0;
    int      miss_cnt = 0;
    bit      drv_acc  = 1'b0;
    bit      acc_prev = 1'b0;

    // Whether the bench intended the pixel consumed at this edge to be accepted.
    always @(posedge clock) acc_prev <= drv_acc;

    // Capture strobes mid-cycle and flag strobes not preceded by an accept.
    always @(negedge clock) begin
        strobe_t s;
        if (enable_lbp) begin
            s.w  = windowIn;
            s.fd = frame_done;
            q.push_back(s);
            if (!acc_prev) spur_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic check(input string name, input logic [W*9-1:0] act, input logic [W*9-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int r, input int c, input bit cmode);
        if (cmode) return 8'h80;
        return 8'((r * COLS + c) % 256);
    endfunction

    function automatic logic [W*9-1:0] exp_win(input int r, input int c, input bit cmode);
        logic [W*9-1:0] w;
        for (int k = 0; k < 9; k++) w[k*W +: W] = exp_pix(r - k / 3, c - k % 3, cmode);
        return w;
    endfunction

    task automatic send(input logic fs, input logic pv, input logic [7:0] px, input bit acc);
        @(posedge clock);
        #1;
        frame_start = fs;
        pixel_valid = pv;
        pixel_in    = px;
        drv_acc     = acc;
    endtask

    task automatic clear_mon();
        q.delete();
        done_cnt = 0;
        spur_cnt = 0;
    endtask

    // Stream one patch; stop_row >= 0 abandons it before that row.
    task automatic run_patch(input bit cmode, input bit stall, input bit fs_first, input int stop_row);
        if (!fs_first) send(1'b1, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            if (r == stop_row) return;
            for (int c = 0; c < COLS; c++) begin
                send(fs_first && r == 0 && c == 0, 1'b1, exp_pix(r, c, cmode), 1'b1);
                if (stall) send(1'b0, 1'b0, 8'hA5, 1'b0);
            end
        end
        repeat (3) send(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_run(input string tag, input bit cmode);
        int n;
        n = (q.size() < NWIN) ? q.size() : NWIN;
        check({tag, "_count"}, 72'(q.size()), 72'(NWIN));
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, q[i].w, exp_win(2 + i / (COLS - 2), 2 + i % (COLS - 2), cmode));
            check({tag, "_done_bit"}, 72'(q[i].fd), 72'(i == NWIN - 1));
        end
        check({tag, "_done_cnt"}, 72'(done_cnt), 72'(1));
        check({tag, "_spurious"}, 72'(spur_cnt), 72'(0));
        check({tag, "_busy_end"}, 72'(busy), 72'(0));
    endtask

    initial begin
        logic [7:0] got;
        tbl[0] = '{0, 8, 8'd0};
        tbl[1] = '{0, 4, 8'd27};
        tbl[2] = '{0, 0, 8'd54};
        tbl[3] = '{23, 0, 8'd77};
        tbl[4] = '{24, 8, 8'd26};
        tbl[5] = '{24, 0, 8'd80};
        tbl[6] = '{575, 8, 8'd109};
        tbl[7] = '{575, 4, 8'd136};
        tbl[8] = '{575, 0, 8'd163};

        reset_lbp   = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_window", windowIn, 72'd0);
        check("rst_enable", 72'(enable_lbp), 72'd0);
        check("rst_done", 72'(frame_done), 72'd0);
        check("rst_busy", 72'(busy), 72'd0);
        @(posedge clock);
        #1;
        reset_lbp = 1'b0;

        // Valid pixels before any frame_start are ignored.
        clear_mon();
        repeat (30) send(1'b0, 1'b1, 8'h11, 1'b0);
        repeat (2) send(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle_strobes", 72'(q.size()), 72'd0);
        check("idle_busy", 72'(busy), 72'd0);

        // Full-rate ramp plus hand-computed slot table.
        clear_mon();
        run_patch(1'b0, 1'b0, 1'b0, -1);
        foreach (tbl[i]) begin
            got = 8'hxx;
            if (tbl[i].idx < q.size()) got = q[tbl[i].idx].w[tbl[i].slot*W +: W];
            check("ramp_table", 72'(got), 72'(tbl[i].exp));
        end
        check_run("ramp", 1'b0);

        // Extra pixels after frame_done are ignored.
        clear_mon();
        repeat (40) send(1'b0, 1'b1, 8'h22, 1'b0);
        repeat (2) send(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_strobes", 72'(q.size()), 72'd0);
        check("post_done", 72'(done_cnt), 72'd0);
        check("post_busy", 72'(busy), 72'd0);

        // Alternating valid.
        clear_mon();
        run_patch(1'b0, 1'b1, 1'b0, -1);
        check_run("stall", 1'b0);

        // frame_start coincident with pixel (0,0).
        clear_mon();
        run_patch(1'b0, 1'b0, 1'b1, -1);
        check_run("fs_first", 1'b0);

        // Reset at row 10, then a clean ramp.
        clear_mon();
        run_patch(1'b0, 1'b0, 1'b0, 10);
        check("mid_busy", 72'(busy), 72'd1);
        @(posedge clock);
        #1;
        reset_lbp   = 1'b1;
        pixel_valid = 1'b0;
        drv_acc     = 1'b0;
        @(posedge clock);
        #1;
        reset_lbp = 1'b0;
        @(negedge clock);
        check("mrst_window", windowIn, 72'd0);
        check("mrst_enable", 72'(enable_lbp), 72'd0);
        check("mrst_busy", 72'(busy), 72'd0);
        repeat (3) send(1'b0, 1'b0, 8'h00, 1'b0);
        check("mrst_no_done", 72'(done_cnt), 72'd0);
        clear_mon();
        run_patch(1'b0, 1'b0, 1'b0, -1);
        check_run("after_reset", 1'b0);

        // Restart at row 5 into a constant 0x80 patch.
        clear_mon();
        run_patch(1'b0, 1'b0, 1'b0, 5);
        repeat (2) send(1'b0, 1'b0, 8'h00, 1'b0);
        check("restart_busy", 72'(busy), 72'd1);
        clear_mon();
        run_patch(1'b1, 1'b0, 1'b0, -1);
        check_run("restart", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
